// File: rtl/mem_port_arbiter_pkg.sv
// Shared core definitions for the memory port arbiter: FSM states and requester ids.
package mem_port_arbiter_pkg;

  // One memory transaction in flight at a time; the busy state records its owner.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_LS_BUSY = 2'd2
  } arb_state_e;

  // Requester identity, also used as the round-robin last-grant value.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin picker: bit 0 = instruction fetch, bit 1 = load/store.
// A lone requester always wins; on contention the one not granted last wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last_grant,
  output logic [1:0] gnt
);

  // Purely combinational one-hot grant.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Request side is driven combinationally from the granted requester in IDLE;
// the owner's response is passed straight through when the memory answers.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_valid_i,
  input  logic [ADDR_W-1:0]   if_req_addr_i,
  output logic                if_req_ready_o,
  output logic                if_rsp_valid_o,
  output logic [ADDR_W-1:0]   if_rsp_addr_o,
  output logic [DATA_W-1:0]   if_rsp_instr_o,
  input  logic                if_flush_i,
  input  logic                ls_req_valid_i,
  input  logic                ls_req_we_i,
  input  logic [DATA_W/8-1:0] ls_req_be_i,
  input  logic [ADDR_W-1:0]   ls_req_addr_i,
  input  logic [DATA_W-1:0]   ls_req_wdata_i,
  output logic                ls_req_ready_o,
  output logic                ls_rsp_valid_o,
  output logic [DATA_W-1:0]   ls_rsp_rdata_o,
  output logic                mem_req_valid_o,
  output logic                mem_req_we_o,
  output logic [DATA_W/8-1:0] mem_req_be_o,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic [DATA_W-1:0]   mem_req_wdata_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_W-1:0]   mem_rsp_rdata_i
);

  arb_state_e        state_q, state_d;
  req_id_e           last_grant_q, last_grant_d;
  logic              kill_q, kill_d;
  logic              ls_we_q, ls_we_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic [1:0]        gnt;
  logic              accept;

  rr_arbiter2 u_rr (
    .req        ({ls_req_valid_i, if_req_valid_i}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_IF;
      kill_q       <= 1'b0;
      ls_we_q      <= 1'b0;
      if_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      kill_q       <= kill_d;
      ls_we_q      <= ls_we_d;
      if_addr_q    <= if_addr_d;
    end
  end

  // Next state and all outputs; request side is gated by rst_ni so reset forces it to zero at once.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    kill_d          = kill_q;
    ls_we_d         = ls_we_q;
    if_addr_d       = if_addr_q;
    accept          = 1'b0;
    if_req_ready_o  = 1'b0;
    if_rsp_valid_o  = 1'b0;
    if_rsp_addr_o   = '0;
    if_rsp_instr_o  = '0;
    ls_req_ready_o  = 1'b0;
    ls_rsp_valid_o  = 1'b0;
    ls_rsp_rdata_o  = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_be_o    = '0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (rst_ni) begin
          accept = (gnt != 2'b00) && mem_req_ready_i;
          if (gnt[0]) begin
            mem_req_valid_o = 1'b1;
            mem_req_be_o    = '1;
            mem_req_addr_o  = if_req_addr_i;
            if (accept) begin
              if_req_ready_o = 1'b1;
              state_d        = ST_IF_BUSY;
              last_grant_d   = REQ_IF;
              if_addr_d      = if_req_addr_i;
              kill_d         = if_flush_i;
            end
          end else if (gnt[1]) begin
            mem_req_valid_o = 1'b1;
            mem_req_we_o    = ls_req_we_i;
            mem_req_be_o    = ls_req_be_i;
            mem_req_addr_o  = ls_req_addr_i;
            mem_req_wdata_o = ls_req_wdata_i;
            if (accept) begin
              ls_req_ready_o = 1'b1;
              state_d        = ST_LS_BUSY;
              last_grant_d   = REQ_LS;
              ls_we_d        = ls_req_we_i;
            end
          end
        end
      end
      ST_IF_BUSY: begin
        if (mem_rsp_valid_i) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          // A redirect seen now or earlier makes this instruction stale.
          if (!kill_q && !if_flush_i) begin
            if_rsp_valid_o = 1'b1;
            if_rsp_addr_o  = if_addr_q;
            if_rsp_instr_o = mem_rsp_rdata_i;
          end
        end else if (if_flush_i) begin
          kill_d = 1'b1;
        end
      end
      ST_LS_BUSY: begin
        if (mem_rsp_valid_i) begin
          state_d        = ST_IDLE;
          ls_rsp_valid_o = 1'b1;
          ls_rsp_rdata_o = ls_we_q ? '0 : mem_rsp_rdata_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_addr;
  logic [31:0] if_rsp_instr;
  logic        if_flush;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [3:0]  ls_req_be;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .if_req_valid_i  (if_req_valid),
    .if_req_addr_i   (if_req_addr),
    .if_req_ready_o  (if_req_ready),
    .if_rsp_valid_o  (if_rsp_valid),
    .if_rsp_addr_o   (if_rsp_addr),
    .if_rsp_instr_o  (if_rsp_instr),
    .if_flush_i      (if_flush),
    .ls_req_valid_i  (ls_req_valid),
    .ls_req_we_i     (ls_req_we),
    .ls_req_be_i     (ls_req_be),
    .ls_req_addr_i   (ls_req_addr),
    .ls_req_wdata_i  (ls_req_wdata),
    .ls_req_ready_o  (ls_req_ready),
    .ls_rsp_valid_o  (ls_rsp_valid),
    .ls_rsp_rdata_o  (ls_rsp_rdata),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_we_o    (mem_req_we),
    .mem_req_be_o    (mem_req_be),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_req_ready_i (mem_req_ready),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_rdata_i (mem_rsp_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    if_flush      = 1'b0;
    ls_req_valid  = 1'b0;
    ls_req_we     = 1'b0;
    ls_req_be     = 4'h0;
    ls_req_addr   = '0;
    ls_req_wdata  = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // One IF-only fetch: grant this cycle, response next cycle.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] instr);
    if_req_valid = 1'b1; if_req_addr = addr;
    sample();
    check({tag, "_if_ready"}, if_req_ready, 1);
    next_cycle();
    if_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = instr;
    sample();
    check({tag, "_rsp_valid"}, if_rsp_valid, 1);
    check({tag, "_rsp_addr"}, if_rsp_addr, addr);
    check({tag, "_rsp_instr"}, if_rsp_instr, instr);
    next_cycle();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    // Reset state: requests present but everything held at zero.
    if_req_valid = 1'b1; if_req_addr = 32'h44;
    sample();
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_if_ready", if_req_ready, 0);
    check("rst_if_rsp", if_rsp_valid, 0);
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;

    // Single fetch, response two cycles after grant.
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    sample();
    check("t1_mem_valid", mem_req_valid, 1);
    check("t1_mem_addr", mem_req_addr, 32'h10);
    check("t1_mem_we", mem_req_we, 0);
    check("t1_mem_be", mem_req_be, 4'hF);
    check("t1_if_ready", if_req_ready, 1);
    check("t1_ls_ready", ls_req_ready, 0);
    next_cycle();
    if_req_addr = 32'h20;
    sample();
    check("t1_busy_if_ready", if_req_ready, 0);
    check("t1_busy_mem_valid", mem_req_valid, 0);
    check("t1_busy_rsp", if_rsp_valid, 0);
    next_cycle();
    if_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h13;
    sample();
    check("t1_rsp_valid", if_rsp_valid, 1);
    check("t1_rsp_addr", if_rsp_addr, 32'h10);
    check("t1_rsp_instr", if_rsp_instr, 32'h13);
    check("t1_ls_rsp", ls_rsp_valid, 0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    sample();
    check("t1_rsp_once", if_rsp_valid, 0);
    next_cycle();
    // Spurious response in IDLE.
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD;
    sample();
    check("spur_if_rsp", if_rsp_valid, 0);
    check("spur_ls_rsp", ls_rsp_valid, 0);
    next_cycle();

    // Contention after reset: LS first, then IF, then alternate.
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h200;
    ls_req_valid = 1'b1; ls_req_addr = 32'h300; ls_req_be = 4'hF;
    sample();
    check("t2_ls_ready", ls_req_ready, 1);
    check("t2_if_ready", if_req_ready, 0);
    check("t2_mem_addr", mem_req_addr, 32'h300);
    next_cycle();
    ls_req_valid = 1'b0;
    sample();
    check("t2_busy_if_ready", if_req_ready, 0);
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAAAA5555;
    sample();
    check("t2_ls_rsp", ls_rsp_valid, 1);
    check("t2_ls_rdata", ls_rsp_rdata, 32'hAAAA5555);
    check("t2_if_rsp", if_rsp_valid, 0);
    check("t2_rsp_if_ready", if_req_ready, 0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    sample();
    check("t2_if_grant", if_req_ready, 1);
    check("t2_if_addr", mem_req_addr, 32'h200);
    next_cycle();
    if_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11;
    sample();
    check("t2_if_rsp_addr", if_rsp_addr, 32'h200);
    next_cycle();
    mem_rsp_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h204;
    ls_req_valid = 1'b1; ls_req_addr = 32'h304;
    sample();
    check("t2_rr_ls_ready", ls_req_ready, 1);
    check("t2_rr_if_ready", if_req_ready, 0);
    next_cycle();
    ls_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0;
    sample();
    check("t2_rr_ls_rsp", ls_rsp_valid, 1);
    next_cycle();
    mem_rsp_valid = 1'b0;
    if_req_addr = 32'h208; ls_req_valid = 1'b1; ls_req_addr = 32'h308;
    sample();
    check("t2_rr2_if_ready", if_req_ready, 1);
    check("t2_rr2_ls_ready", ls_req_ready, 0);
    check("t2_rr2_addr", mem_req_addr, 32'h208);
    next_cycle();
    idle_inputs();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h22;
    sample();
    check("t2_rr2_if_rsp", if_rsp_valid, 1);
    next_cycle();
    idle_inputs();

    // Flush one cycle after grant.
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    sample();
    check("t3_grant", if_req_ready, 1);
    next_cycle();
    if_req_valid = 1'b0; if_flush = 1'b1;
    sample();
    next_cycle();
    if_flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEADBEEF;
    sample();
    check("t3_killed_rsp", if_rsp_valid, 0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    fetch("t3_after", 32'h44, 32'h55);
    // Flush coincident with response.
    if_req_valid = 1'b1; if_req_addr = 32'h48;
    sample();
    next_cycle();
    if_req_valid = 1'b0; if_flush = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h66;
    sample();
    check("t3_same_cycle_drop", if_rsp_valid, 0);
    next_cycle();
    idle_inputs();
    fetch("t3_after2", 32'h4C, 32'h77);
    // Flush in the grant cycle itself.
    if_req_valid = 1'b1; if_req_addr = 32'h50; if_flush = 1'b1;
    sample();
    check("t3_grant_flush_ready", if_req_ready, 1);
    next_cycle();
    idle_inputs();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h88;
    sample();
    check("t3_grant_flush_drop", if_rsp_valid, 0);
    next_cycle();
    idle_inputs();
    // Flush has no effect on a load.
    ls_req_valid = 1'b1; ls_req_addr = 32'h500; ls_req_be = 4'hF;
    sample();
    check("t3_ls_grant", ls_req_ready, 1);
    next_cycle();
    ls_req_valid = 1'b0; if_flush = 1'b1;
    sample();
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE;
    sample();
    check("t3_ls_rsp_flush", ls_rsp_valid, 1);
    check("t3_ls_rdata_flush", ls_rsp_rdata, 32'hCAFE);
    next_cycle();
    idle_inputs();

    // Store stalled by mem_req_ready low for three cycles.
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_be = 4'b0011;
    ls_req_addr = 32'h100; ls_req_wdata = 32'h1234; mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t4_stall_valid", mem_req_valid, 1);
      check("t4_stall_addr", mem_req_addr, 32'h100);
      check("t4_stall_be", mem_req_be, 4'b0011);
      check("t4_stall_wdata", mem_req_wdata, 32'h1234);
      check("t4_stall_we", mem_req_we, 1);
      check("t4_stall_ready", ls_req_ready, 0);
      next_cycle();
    end
    mem_req_ready = 1'b1;
    sample();
    check("t4_accept", ls_req_ready, 1);
    next_cycle();
    ls_req_valid = 1'b0; ls_req_we = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFFFFFF;
    sample();
    check("t4_ack", ls_rsp_valid, 1);
    check("t4_ack_rdata", ls_rsp_rdata, 0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    sample();
    check("t4_ack_once", ls_rsp_valid, 0);
    next_cycle();

    // Reset during LS_BUSY, late response afterwards.
    ls_req_valid = 1'b1; ls_req_addr = 32'h600; ls_req_be = 4'hF;
    sample();
    check("t5_ls_grant", ls_req_ready, 1);
    next_cycle();
    ls_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h70;
    rst_n = 1'b0;
    #1;
    check("t5_rst_mem_valid", mem_req_valid, 0);
    check("t5_rst_mem_addr", mem_req_addr, 0);
    check("t5_rst_if_ready", if_req_ready, 0);
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111;
    sample();
    check("t5_late_ls_rsp", ls_rsp_valid, 0);
    check("t5_late_if_rsp", if_rsp_valid, 0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    fetch("t5_next", 32'h80, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
